mod60: RTL and testbench

MOD60 -- requirements
Module: mod60

---
 rtl/timer0_pkg.sv | 14 +
 rtl/mod60_bcd_digit.sv | 31 +++
 rtl/mod60.sv | 58 +++++
 tb/tb_mod60.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer0_pkg.sv
// Shared constants for the BCD timer stages: digit widths, digit limits and
// a helper that decides whether a 7-bit BCD preset is a legal minute/second value.
package timer0_pkg;
    localparam int DIGIT_W  = 4;
    localparam int ONES_MAX = 9;
    localparam int TENS_MAX = 5;
    localparam int CNT_W    = 7;
    localparam int TENS_W   = CNT_W - DIGIT_W;

    function automatic logic bcd60_valid(input logic [CNT_W-1:0] val);
        return (val[CNT_W-1:DIGIT_W] <= TENS_W'(TENS_MAX)) &&
               (val[DIGIT_W-1:0] <= DIGIT_W'(ONES_MAX));
    endfunction
endpackage

// File: rtl/mod60_bcd_digit.sv
// One BCD digit: loads, or increments on inc_in and wraps at MAX.
// carry_out is combinational so the next digit advances on the same edge.
module bcd_digit #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_in,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] digit,
    output logic         carry_out
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= load_val;
        end else if (inc_in) begin
            r_digit <= (r_digit == MAX_V) ? '0 : r_digit + 1'b1;
        end
    end

    assign digit     = r_digit;
    assign carry_out = inc_in & (r_digit == MAX_V);
endmodule

// File: rtl/mod60.sv
// BCD 00..59 counter with validated preset; tc cascades into the hour stage.
// A rejected preset leaves the count alone and raises load_err for one cycle.
module mod60
    import timer0_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc,
    output logic [CNT_W-1:0] cnt_num,
    output logic             load_err
);
    logic              w_load_ok;
    logic              w_inc;
    logic              w_ones_carry;
    logic              w_tens_carry;
    logic [DIGIT_W-1:0] w_ones;
    logic [TENS_W-1:0]  w_tens;
    logic              r_load_err;

    assign w_load_ok = load & bcd60_valid(load_val);
    // Any load strobe, valid or not, swallows the en tick of that cycle.
    assign w_inc     = en & ~load;

    bcd_digit #(.W(DIGIT_W), .MAX(ONES_MAX)) u_ones (
        .clk       (clk),
        .rst       (rst),
        .inc_in    (w_inc),
        .load      (w_load_ok),
        .load_val  (load_val[DIGIT_W-1:0]),
        .digit     (w_ones),
        .carry_out (w_ones_carry)
    );

    bcd_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_tens (
        .clk       (clk),
        .rst       (rst),
        .inc_in    (w_ones_carry),
        .load      (w_load_ok),
        .load_val  (load_val[CNT_W-1:DIGIT_W]),
        .digit     (w_tens),
        .carry_out (w_tens_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & ~w_load_ok;
        end
    end

    assign cnt_num  = {w_tens, w_ones};
    assign tc       = w_tens_carry;
    assign load_err = r_load_err;
endmodule

// File: tb/tb_mod60.sv
// Self-checking bench for mod60: directed scenarios plus random traffic
// compared against an integer-valued reference model of the seconds counter.
module tb_mod60;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = 7'h00;
    logic       tc;
    logic [6:0] cnt_num;
    logic       load_err;

    int total = 0;
    int bad = 0;
    int m_cnt = 0;
    bit m_err = 0;
    int m_hour = 0;

    mod60 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .tc       (tc),
        .cnt_num  (cnt_num),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] to_bcd(input int v);
        logic [6:0] r;
        r = 7'((v / 10) * 16 + (v % 10));
        return r;
    endfunction

    // Drive one cycle, sample tc before the edge, then advance the model.
    task automatic do_cycle(input bit e, input bit l, input logic [6:0] v,
                            output logic tc_obs, output logic tc_exp);
        int tens;
        int ones;
        @(negedge clk);
        en = e; load = l; load_val = v;
        #1;
        tc_obs = tc;
        tc_exp = e && !l && (m_cnt == 59);
        @(posedge clk);
        tens = int'(v) / 16;
        ones = int'(v) % 16;
        if (l) begin
            if (tens <= 5 && ones <= 9) begin
                m_cnt = tens * 10 + ones;
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_err = 0;
            if (e) m_cnt = (m_cnt + 1) % 60;
        end
        if (tc_exp) m_hour = (m_hour + 1) % 12;
        #1;
        en = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        #3;
        total++;
        if (cnt_num !== 7'h00 || load_err !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cnt=%h err=%b tc=%b required cnt=00 err=0 tc=0", cnt_num, load_err, tc);
        end
        #27;
        total++;
        if (cnt_num !== 7'h00 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: cnt=%h tc=%b required cnt=00 tc=0", cnt_num, tc);
        end
        en = 1'b0;
        rst = 1'b0;
        m_cnt = 0; m_err = 0;
    endtask

    task automatic test_count10();
        logic to, te;
        for (int i = 1; i <= 10; i++) begin
            do_cycle(1, 0, 7'h00, to, te);
            total++;
            if (cnt_num !== to_bcd(i) || to !== 1'b0) begin
                bad++;
                $display("FAIL count10[%0d]: cnt=%h tc=%b required cnt=%h tc=0", i, cnt_num, to, to_bcd(i));
            end
        end
    endtask

    task automatic test_full_wrap();
        logic to, te;
        int pulses;
        int hour_before;
        do_cycle(0, 1, 7'h00, to, te);
        hour_before = m_hour;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            do_cycle(1, 0, 7'h00, to, te);
            if (to === 1'b1) pulses++;
            total++;
            if (to !== (i == 59)) begin
                bad++;
                $display("FAIL wrap_tc[%0d]: tc=%b required %b", i, to, (i == 59));
            end
        end
        total++;
        if (cnt_num !== 7'h00) begin
            bad++;
            $display("FAIL wrap_return: cnt=%h required 00", cnt_num);
        end
        total++;
        if (pulses != 1 || m_hour != (hour_before + 1) % 12) begin
            bad++;
            $display("FAIL wrap_hour_advance: tc pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_load_priority();
        logic to, te;
        do_cycle(1, 1, 7'h45, to, te);
        total++;
        if (cnt_num !== 7'h45 || load_err !== 1'b0 || to !== 1'b0) begin
            bad++;
            $display("FAIL load_priority: cnt=%h err=%b tc=%b required cnt=45 err=0 tc=0", cnt_num, load_err, to);
        end
    endtask

    task automatic test_invalid_load();
        logic to, te;
        logic exp_err [3] = '{1'b1, 1'b1, 1'b0};
        do_cycle(0, 1, 7'h12, to, te);
        do_cycle(1, 1, 7'h5A, to, te);
        total++;
        if (cnt_num !== 7'h12 || load_err !== exp_err[0]) begin
            bad++;
            $display("FAIL invalid_load_5A: cnt=%h err=%b required cnt=12 err=1", cnt_num, load_err);
        end
        do_cycle(1, 1, 7'h63, to, te);
        total++;
        if (cnt_num !== 7'h12 || load_err !== exp_err[1]) begin
            bad++;
            $display("FAIL invalid_load_63: cnt=%h err=%b required cnt=12 err=1", cnt_num, load_err);
        end
        do_cycle(0, 0, 7'h00, to, te);
        total++;
        if (cnt_num !== 7'h12 || load_err !== exp_err[2]) begin
            bad++;
            $display("FAIL invalid_load_clear: cnt=%h err=%b required cnt=12 err=0", cnt_num, load_err);
        end
    endtask

    task automatic test_load59();
        logic to, te;
        do_cycle(1, 1, 7'h59, to, te);
        total++;
        if (to !== 1'b0 || cnt_num !== 7'h59) begin
            bad++;
            $display("FAIL load59_loadcycle: tc=%b cnt=%h required tc=0 cnt=59", to, cnt_num);
        end
        do_cycle(1, 0, 7'h00, to, te);
        total++;
        if (to !== 1'b1 || cnt_num !== 7'h00) begin
            bad++;
            $display("FAIL load59_tick: tc=%b cnt=%h required tc=1 cnt=00", to, cnt_num);
        end
    endtask

    task automatic test_random();
        logic to, te;
        bit e, l;
        logic [6:0] v;
        for (int i = 0; i < 300; i++) begin
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 7) == 0);
            v = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) v = 7'h59;
            do_cycle(e, l, v, to, te);
            total++;
            if (cnt_num !== to_bcd(m_cnt) || load_err !== m_err || to !== te) begin
                bad++;
                $display("FAIL random[%0d]: cnt=%h err=%b tc=%b required cnt=%h err=%b tc=%b",
                         i, cnt_num, load_err, to, to_bcd(m_cnt), m_err, te);
            end
        end
    endtask

    task automatic test_async_reset();
        logic to, te;
        do_cycle(0, 1, 7'h37, to, te);
        @(negedge clk);
        en = 1'b1;
        load = 1'b1;
        load_val = 7'h22;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cnt_num !== 7'h00 || load_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: cnt=%h err=%b required cnt=00 err=0", cnt_num, load_err);
        end
        @(posedge clk);
        #1;
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0; m_err = 0;
        do_cycle(1, 0, 7'h00, to, te);
        total++;
        if (cnt_num !== 7'h01) begin
            bad++;
            $display("FAIL reset_then_tick: cnt=%h required 01", cnt_num);
        end
    endtask

    initial begin
        test_reset();
        test_count10();
        test_full_wrap();
        test_load_priority();
        test_invalid_load();
        test_load59();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
